seg7_scan_driver: RTL

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

---
 rtl/seg7_scan_driver.sv | 128 ++++++++++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment scan driver: one digit lit per slot, with a blanked
// lead-in each slot so the anode switch never overlaps the segment change.
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 8,
  parameter int SLOT_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  i_en,
  input  logic [6:0]            i_hex [0:NUM_DIGITS-1],
  input  logic [NUM_DIGITS-1:0] i_dp,
  output logic [6:0]            o_seg,
  output logic                  o_dp_n,
  output logic [NUM_DIGITS-1:0] o_an,
  output logic                  o_frame
);

  localparam int CNT_W = $clog2(SLOT_CYCLES);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {S_OFF, S_BLANK, S_DRIVE} state_t;

  state_t                r_state, w_state_next;
  logic [CNT_W-1:0]      r_cnt, w_cnt_next;
  logic [IDX_W-1:0]      r_idx, w_idx_next;
  logic [6:0]            r_snap_seg, w_snap_seg_next;
  logic                  r_snap_dp, w_snap_dp_next;
  logic [NUM_DIGITS-1:0] w_an_next;
  logic [6:0]            w_seg_next;
  logic                  w_dp_n_next;
  logic                  w_frame_next;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state    <= S_OFF;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_snap_seg <= 7'h7F;
      r_snap_dp  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_idx      <= w_idx_next;
      r_snap_seg <= w_snap_seg_next;
      r_snap_dp  <= w_snap_dp_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_idx_next      = r_idx;
    w_snap_seg_next = r_snap_seg;
    w_snap_dp_next  = r_snap_dp;
    if (!i_en) begin
      w_state_next = S_OFF;
      w_cnt_next   = '0;
      w_idx_next   = '0;
    end else begin
      case (r_state)
        S_OFF: begin
          w_state_next = S_BLANK;
          w_cnt_next   = '0;
          w_idx_next   = '0;
        end
        S_BLANK: begin
          // Latch the digit once per slot so later input changes cannot tear it.
          if (r_cnt == '0) begin
            w_snap_seg_next = i_hex[r_idx];
            w_snap_dp_next  = i_dp[r_idx];
          end
          w_cnt_next = r_cnt + 1'b1;
          if (r_cnt == BLANK_LAST) w_state_next = S_DRIVE;
        end
        S_DRIVE: begin
          if (r_cnt == SLOT_LAST) begin
            w_state_next = S_BLANK;
            w_cnt_next   = '0;
            w_idx_next   = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_next = S_OFF;
          w_cnt_next   = '0;
          w_idx_next   = '0;
        end
      endcase
    end
  end

  // Outputs decode the next state so they line up with the state they describe.
  always_comb begin
    w_seg_next   = 7'h7F;
    w_dp_n_next  = 1'b1;
    w_frame_next = (w_state_next == S_BLANK) && (w_cnt_next == '0) && (w_idx_next == '0);
    if (w_state_next == S_DRIVE) begin
      w_seg_next  = w_snap_seg_next;
      w_dp_n_next = ~w_snap_dp_next;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_an
      assign w_an_next[gi] = !((w_state_next == S_DRIVE) && (w_idx_next == IDX_W'(gi)));
    end
  endgenerate

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      o_an    <= '1;
      o_seg   <= 7'h7F;
      o_dp_n  <= 1'b1;
      o_frame <= 1'b0;
    end else begin
      o_an    <= w_an_next;
      o_seg   <= w_seg_next;
      o_dp_n  <= w_dp_n_next;
      o_frame <= w_frame_next;
    end
  end

endmodule
